// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: shared codes for the ALU writeback stage.
// Holds destination codes, p_op codes, P bit indices and FSM states.
package alu_result_stage_pkg;
    localparam logic [1:0] DEST_NONE = 2'b00;
    localparam logic [1:0] DEST_A    = 2'b01;
    localparam logic [1:0] DEST_X    = 2'b10;
    localparam logic [1:0] DEST_Y    = 2'b11;
    localparam logic [2:0] POP_NOP = 3'd0;
    localparam logic [2:0] POP_CLC = 3'd1;
    localparam logic [2:0] POP_SEC = 3'd2;
    localparam logic [2:0] POP_CLI = 3'd3;
    localparam logic [2:0] POP_SEI = 3'd4;
    localparam logic [2:0] POP_CLD = 3'd5;
    localparam logic [2:0] POP_SED = 3'd6;
    localparam logic [2:0] POP_CLV = 3'd7;
    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;
    typedef enum logic [1:0] {S_IDLE, S_DEC_LO, S_DEC_HI, S_COMMIT} state_e;
endpackage

// File: rtl/alu_result_stage_bcd_adjust.sv
// alu_result_stage_bcd_adjust: one NMOS decimal-adjust step, low nibble (phase 0) or high nibble (phase 1).
module alu_result_stage_bcd_adjust (
    input  logic [7:0] i_val,
    input  logic       i_c,
    input  logic       i_hc,
    input  logic       i_sub,
    input  logic       i_phase,
    output logic [7:0] o_val,
    output logic       o_c
);
    logic       w_lo_fix, w_hi_fix;
    logic [7:0] w_lo_val, w_hi_val;
    always_comb begin
        w_lo_fix = i_sub ? !i_hc : (i_val[3:0] > 4'd9 || i_hc);
        w_hi_fix = i_sub ? !i_c : (i_val[7:4] > 4'd9 || i_c);
        // SBC has already borrowed into the high nibble, so its low fix must not ripple upward
        w_lo_val = i_sub ? {i_val[7:4], i_val[3:0] - 4'd6} : i_val + 8'h06;
        w_hi_val = i_sub ? i_val - 8'h60 : i_val + 8'h60;
        o_val = i_phase ? (w_hi_fix ? w_hi_val : i_val) : (w_lo_fix ? w_lo_val : i_val);
        o_c = (i_phase && w_hi_fix) ? !i_sub : i_c;
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU writeback stage committing A/X/Y and maintaining P (flags, flag ops, PLP/RTI).
// Define DECIMAL_MODE_EN to enable the two-cycle NMOS BCD correction path.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int         DATA_W  = 8,
    parameter logic [7:0] P_RESET = 8'h34
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] alu_Y,
    input  logic              alu_carry_out,
    input  logic              alu_overflow,
    input  logic              alu_half_carry,
    input  logic [1:0]        res_dest,
    input  logic [3:0]        res_flag_mask,
    input  logic              res_decimal,
    input  logic              res_sub,
    input  logic [2:0]        p_op,
    input  logic              p_load,
    input  logic [7:0]        p_load_data,
    output logic [DATA_W-1:0] reg_A,
    output logic [DATA_W-1:0] reg_X,
    output logic [DATA_W-1:0] reg_Y,
    output logic [7:0]        reg_P,
    output logic              wb_done
);
    state_e            r_state, w_next;
    logic [DATA_W-1:0] r_val, r_bin, r_a, r_x, r_y;
    logic [7:0]        r_p, w_p;
    logic [1:0]        r_dest;
    logic [3:0]        r_mask;
    logic              r_c, r_v, r_done, w_accept, w_commit, w_dec_go;
`ifdef DECIMAL_MODE_EN
    logic              r_hc, r_sub, w_adj_c;
    logic [DATA_W-1:0] w_adj_val;
    assign w_dec_go = res_decimal && r_p[P_D];
    alu_result_stage_bcd_adjust u_bcd (
        .i_val  (r_val),
        .i_c    (r_c),
        .i_hc   (r_hc),
        .i_sub  (r_sub),
        .i_phase(r_state == S_DEC_HI),
        .o_val  (w_adj_val),
        .o_c    (w_adj_c)
    );
`else
    logic w_unused;
    assign w_unused = &{1'b0, alu_half_carry, res_decimal, res_sub};
    assign w_dec_go = 1'b0;
`endif
    assign res_ready = (r_state == S_IDLE);
    assign w_accept  = res_valid && res_ready;
    assign w_commit  = (r_state == S_COMMIT);
    assign reg_A     = r_a;
    assign reg_X     = r_x;
    assign reg_Y     = r_y;
    assign reg_P     = r_p;
    assign wb_done   = r_done;
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = w_accept ? (w_dec_go ? S_DEC_LO : S_COMMIT) : S_IDLE;
            S_DEC_LO: w_next = S_DEC_HI;
            S_DEC_HI: w_next = S_COMMIT;
            default:  w_next = S_IDLE;
        endcase
    end
    // Later assignments win: p_load over commit over p_op
    always_comb begin
        w_p = r_p;
        case (p_op)
            POP_CLC: w_p[P_C] = 1'b0;
            POP_SEC: w_p[P_C] = 1'b1;
            POP_CLI: w_p[P_I] = 1'b0;
            POP_SEI: w_p[P_I] = 1'b1;
            POP_CLD: w_p[P_D] = 1'b0;
            POP_SED: w_p[P_D] = 1'b1;
            POP_CLV: w_p[P_V] = 1'b0;
            default: ;
        endcase
        if (w_commit && r_mask[3]) w_p[P_N] = r_bin[DATA_W-1];
        if (w_commit && r_mask[2]) w_p[P_V] = r_v;
        if (w_commit && r_mask[1]) w_p[P_Z] = (r_bin == '0);
        if (w_commit && r_mask[0]) w_p[P_C] = r_c;
        if (p_load) w_p = p_load_data;
        w_p[5:4] = 2'b11;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_p     <= P_RESET;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_val   <= '0;
            r_bin   <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_dest  <= DEST_NONE;
            r_mask  <= 4'b0;
`ifdef DECIMAL_MODE_EN
            r_hc    <= 1'b0;
            r_sub   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_p     <= w_p;
            r_done  <= w_commit;
            if (w_accept) begin
                r_val  <= alu_Y;
                r_bin  <= alu_Y;
                r_c    <= alu_carry_out;
                r_v    <= alu_overflow;
                r_dest <= res_dest;
                r_mask <= res_flag_mask;
            end
`ifdef DECIMAL_MODE_EN
            if (w_accept) begin
                r_hc  <= alu_half_carry;
                r_sub <= res_sub;
            end
            if (r_state == S_DEC_LO || r_state == S_DEC_HI) begin
                r_val <= w_adj_val;
                r_c   <= w_adj_c;
            end
`endif
            if (w_commit && r_dest == DEST_A) r_a <= r_val;
            if (w_commit && r_dest == DEST_X) r_x <= r_val;
            if (w_commit && r_dest == DEST_Y) r_y <= r_val;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage.
// Expectations follow DECIMAL_MODE_EN when the bench is built with it.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;
`ifdef DECIMAL_MODE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif
    localparam int DLAT = DEC ? 4 : 2;

    logic       clk, resetn, res_valid, res_ready, alu_carry_out, alu_overflow, alu_half_carry;
    logic       res_decimal, res_sub, p_load, wb_done;
    logic [7:0] alu_Y, p_load_data, reg_A, reg_X, reg_Y, reg_P;
    logic [1:0] res_dest;
    logic [3:0] res_flag_mask;
    logic [2:0] p_op;
    int         checks = 0;
    int         errors = 0;

    alu_result_stage dut (
        .clk(clk), .resetn(resetn), .res_valid(res_valid), .res_ready(res_ready),
        .alu_Y(alu_Y), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
        .alu_half_carry(alu_half_carry), .res_dest(res_dest), .res_flag_mask(res_flag_mask),
        .res_decimal(res_decimal), .res_sub(res_sub), .p_op(p_op), .p_load(p_load),
        .p_load_data(p_load_data), .reg_A(reg_A), .reg_X(reg_X), .reg_Y(reg_Y),
        .reg_P(reg_P), .wb_done(wb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic [7:0] y, input logic c, v, hc, input logic [1:0] dest,
                            input logic [3:0] mask, input logic dec, sub);
        alu_Y = y; alu_carry_out = c; alu_overflow = v; alu_half_carry = hc;
        res_dest = dest; res_flag_mask = mask; res_decimal = dec; res_sub = sub;
    endtask

    // Issues one op and waits for its wb_done, optionally placing a p_op/p_load on the commit edge
    task automatic run_op(input string name, input logic [7:0] y, input logic c, v, hc,
                          input logic [1:0] dest, input logic [3:0] mask, input logic dec, sub,
                          input int exp_lat, input logic [2:0] cop, input logic cld,
                          input logic [7:0] cdata);
        int lat;
        @(negedge clk);
        drive_op(y, c, v, hc, dest, mask, dec, sub);
        res_valid = 1'b1;
        checks++;
        if (res_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, res_ready);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            res_valid = 1'b0;
            if (lat == 1) begin
                checks++;
                if (res_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_after_accept: got %b expected 0", name, res_ready);
                end
            end
            p_op = (lat == exp_lat - 1) ? cop : POP_NOP;
            p_load = (lat == exp_lat - 1) && cld;
            p_load_data = cdata;
        end while (wb_done !== 1'b1 && lat < 8);
        p_op = POP_NOP;
        p_load = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        @(negedge clk);
        checks++;
        if (wb_done !== 1'b0) begin
            errors++;
            $display("FAIL %s wb_done_pulse: got %b expected 0", name, wb_done);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        res_valid = 1'b0; p_op = POP_NOP; p_load = 1'b0; p_load_data = 8'h00;
        drive_op(8'h00, 1'b0, 1'b0, 1'b0, DEST_NONE, 4'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({reg_A, reg_X, reg_Y} !== 24'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 000000", {reg_A, reg_X, reg_Y});
        end
        checks++;
        if (reg_P !== 8'h34 || wb_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_p: got P=%h wb=%b expected P=34 wb=0", reg_P, wb_done);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", res_ready);
        end
    endtask

    task automatic test_binary;
        run_op("bin_zero", 8'h00, 1'b1, 1'b0, 1'b0, DEST_A, 4'b1111, 1'b0, 1'b0, 2, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_A !== 8'h00 || reg_P !== 8'h37) begin
            errors++;
            $display("FAIL bin_zero: got A=%h P=%h expected A=00 P=37", reg_A, reg_P);
        end
        run_op("bin_neg", 8'h80, 1'b0, 1'b1, 1'b0, DEST_X, 4'b1111, 1'b0, 1'b0, 2, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_X !== 8'h80 || reg_P !== 8'hF4) begin
            errors++;
            $display("FAIL bin_neg: got X=%h P=%h expected X=80 P=F4", reg_X, reg_P);
        end
        run_op("bin_mask", 8'hC3, 1'b1, 1'b0, 1'b0, DEST_Y, 4'b0011, 1'b0, 1'b0, 2, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_Y !== 8'hC3 || reg_P !== 8'hF5) begin
            errors++;
            $display("FAIL bin_mask: got Y=%h P=%h expected Y=C3 P=F5", reg_Y, reg_P);
        end
        run_op("bin_none", 8'h00, 1'b0, 1'b0, 1'b0, DEST_NONE, 4'b0010, 1'b0, 1'b0, 2, POP_NOP, 1'b0, 8'h00);
        checks++;
        if ({reg_A, reg_X, reg_Y} !== 24'h0080C3 || reg_P !== 8'hF7) begin
            errors++;
            $display("FAIL bin_none: got AXY=%h P=%h expected AXY=0080C3 P=F7", {reg_A, reg_X, reg_Y}, reg_P);
        end
    endtask

    task automatic test_flags;
        logic [2:0] t_op  [12] = '{POP_CLC, POP_CLV, POP_SEC, POP_NOP, POP_NOP, POP_CLI,
                                   POP_SEI, POP_CLD, POP_SED, POP_SEC, POP_NOP, POP_NOP};
        logic [11:0] t_ld = 12'b1110_0001_1000;
        logic [7:0] t_dat [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'hCF, 8'h00};
        logic [7:0] t_exp [12] = '{8'hF6, 8'hB6, 8'hB7, 8'h30, 8'hFF, 8'hFB,
                                   8'hFF, 8'hF7, 8'hFF, 8'h30, 8'hFF, 8'h30};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            p_op = t_op[i];
            p_load = t_ld[i];
            p_load_data = t_dat[i];
            @(negedge clk);
            p_op = POP_NOP;
            p_load = 1'b0;
            checks++;
            if (reg_P !== t_exp[i]) begin
                errors++;
                $display("FAIL flags[%0d]: got P=%h expected %h", i, reg_P, t_exp[i]);
            end
        end
    endtask

    task automatic test_commit_priority;
        run_op("clc_vs_commit", 8'h01, 1'b1, 1'b0, 1'b0, DEST_NONE, 4'b0001, 1'b0, 1'b0, 2, POP_CLC, 1'b0, 8'h00);
        checks++;
        if (reg_P !== 8'h31) begin
            errors++;
            $display("FAIL clc_vs_commit: got P=%h expected 31", reg_P);
        end
        run_op("load_vs_commit", 8'h01, 1'b1, 1'b0, 1'b0, DEST_NONE, 4'b0001, 1'b0, 1'b0, 2, POP_NOP, 1'b1, 8'h00);
        checks++;
        if (reg_P !== 8'h30) begin
            errors++;
            $display("FAIL load_vs_commit: got P=%h expected 30", reg_P);
        end
        run_op("sec_unmasked", 8'h01, 1'b0, 1'b0, 1'b0, DEST_NONE, 4'b0000, 1'b0, 1'b0, 2, POP_SEC, 1'b0, 8'h00);
        checks++;
        if (reg_P !== 8'h31) begin
            errors++;
            $display("FAIL sec_unmasked: got P=%h expected 31", reg_P);
        end
    endtask

    task automatic test_decimal;
        @(negedge clk);
        p_load = 1'b1;
        p_load_data = 8'h08;
        @(negedge clk);
        p_load = 1'b0;
        checks++;
        if (reg_P !== 8'h38) begin
            errors++;
            $display("FAIL dec_setd: got P=%h expected 38", reg_P);
        end
        run_op("adc_0a", 8'h0A, 1'b0, 1'b0, 1'b0, DEST_A, 4'b1111, 1'b1, 1'b0, DLAT, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_A !== (DEC ? 8'h10 : 8'h0A) || reg_P !== 8'h38) begin
            errors++;
            $display("FAIL adc_0a: got A=%h P=%h expected A=%h P=38", reg_A, reg_P, DEC ? 8'h10 : 8'h0A);
        end
        run_op("adc_9a", 8'h9A, 1'b0, 1'b0, 1'b0, DEST_A, 4'b1111, 1'b1, 1'b0, DLAT, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_A !== (DEC ? 8'h00 : 8'h9A) || reg_P !== (DEC ? 8'hB9 : 8'hB8)) begin
            errors++;
            $display("FAIL adc_9a: got A=%h P=%h expected A=%h P=%h", reg_A, reg_P,
                     DEC ? 8'h00 : 8'h9A, DEC ? 8'hB9 : 8'hB8);
        end
        run_op("sbc_0f", 8'h0F, 1'b1, 1'b0, 1'b0, DEST_A, 4'b0001, 1'b1, 1'b1, DLAT, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_A !== (DEC ? 8'h09 : 8'h0F) || reg_P !== 8'hB9) begin
            errors++;
            $display("FAIL sbc_0f: got A=%h P=%h expected A=%h P=B9", reg_A, reg_P, DEC ? 8'h09 : 8'h0F);
        end
        run_op("sbc_ff", 8'hFF, 1'b0, 1'b0, 1'b0, DEST_A, 4'b0001, 1'b1, 1'b1, DLAT, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_A !== (DEC ? 8'h99 : 8'hFF) || reg_P !== 8'hB8) begin
            errors++;
            $display("FAIL sbc_ff: got A=%h P=%h expected A=%h P=B8", reg_A, reg_P, DEC ? 8'h99 : 8'hFF);
        end
        @(negedge clk);
        p_op = POP_CLD;
        @(negedge clk);
        p_op = POP_NOP;
        run_op("dec_dclear", 8'h0A, 1'b0, 1'b0, 1'b0, DEST_X, 4'b0000, 1'b1, 1'b0, 2, POP_NOP, 1'b0, 8'h00);
        checks++;
        if (reg_X !== 8'h0A || reg_P !== 8'hB0) begin
            errors++;
            $display("FAIL dec_dclear: got X=%h P=%h expected X=0A P=B0", reg_X, reg_P);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        p_op = POP_SED;
        @(negedge clk);
        p_op = POP_NOP;
        drive_op(8'h0A, 1'b0, 1'b0, 1'b0, DEST_A, 4'b0000, 1'b1, 1'b0);
        res_valid = 1'b1;
        @(negedge clk);
        drive_op(8'h33, 1'b0, 1'b0, 1'b0, DEST_X, 4'b0000, 1'b0, 1'b0);
        n = 1;
        while (wb_done !== 1'b1 && n < 8) begin
            checks++;
            if (res_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_busy[%0d]: got %b expected 0", n, res_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != DLAT || reg_A !== (DEC ? 8'h10 : 8'h0A) || res_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got lat=%0d A=%h ready=%b expected lat=%0d A=%h ready=1",
                     n, reg_A, res_ready, DLAT, DEC ? 8'h10 : 8'h0A);
        end
        @(negedge clk);
        res_valid = 1'b0;
        n = 1;
        while (wb_done !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2 || reg_X !== 8'h33 || reg_A !== (DEC ? 8'h10 : 8'h0A)) begin
            errors++;
            $display("FAIL bp_second: got lat=%0d X=%h A=%h expected lat=2 X=33 A=%h",
                     n, reg_X, reg_A, DEC ? 8'h10 : 8'h0A);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        drive_op(8'h0A, 1'b0, 1'b0, 1'b0, DEST_Y, 4'b1111, 1'b1, 1'b0);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if ({reg_A, reg_X, reg_Y} !== 24'h0 || reg_P !== 8'h34 || wb_done !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: got AXY=%h P=%h wb=%b expected AXY=000000 P=34 wb=0",
                     {reg_A, reg_X, reg_Y}, reg_P, wb_done);
        end
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if (res_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_ready: got %b expected 1", res_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wb_done !== 1'b0 || reg_Y !== 8'h00) begin
                errors++;
                $display("FAIL midop_quiet[%0d]: got wb=%b Y=%h expected wb=0 Y=00", i, wb_done, reg_Y);
            end
        end
    endtask

    initial begin
        test_reset;
        test_binary;
        test_flags;
        test_commit_priority;
        test_decimal;
        test_back_to_back;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Writeback stage directly downstream of the ALU; consumes alu_Y, carry, overflow and half-carry for one operation at a time.
- Optionally applies NMOS-style BCD correction across two extra cycles, then commits the result to A, X, Y or none.
- Updates N/Z/C/V in the processor status register P; also services flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV) and PLP/RTI loads.

Parameters:
- DATA_W, 8, datapath width; only 8 is supported, and the BCD logic assumes 8.
- P_RESET, 8'h34, P value after reset: I=1, bits 5 and 4 read 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- res_valid  in  1  an ALU result is presented this cycle.
- res_ready  out  1  stage can accept; high only in IDLE.
- alu_Y  in  8  ALU binary result.
- alu_carry_out  in  1  ALU carry (borrow-not for subtract).
- alu_overflow  in  1  ALU signed overflow.
- alu_half_carry  in  1  carry out of bit 3.
- res_dest  in  2  00 none, 01 A, 10 X, 11 Y.
- res_flag_mask  in  4  update enables {N,V,Z,C}.
- res_decimal  in  1  ADC/SBC executed with D set.
- res_sub  in  1  operation was SBC.
- p_op  in  3  000 nop, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLD, 110 SED, 111 CLV.
- p_load  in  1  load P from p_load_data (PLP/RTI).
- p_load_data  in  8  value popped from stack.
- reg_A, reg_X, reg_Y  out  8 each  architectural registers.
- reg_P  out  8  {N,V,1,1,D,I,Z,C}.
- wb_done  out  1  one-cycle pulse, high in the cycle committed values are first visible.

Behaviour:
- Reset (async): A, X, Y = 0; P = P_RESET; state = IDLE; wb_done = 0; held operands discarded.
- Accept when res_valid && res_ready. At the accept edge, capture Y, C, V, HC, dest, mask, decimal and sub.
- Next state: DEC_LO if (decimal && D flag && DECIMAL_MODE_EN), otherwise COMMIT.
- FSM: IDLE -> COMMIT -> IDLE for binary; IDLE -> DEC_LO -> DEC_HI -> COMMIT -> IDLE for decimal.
- DEC_LO, add (ADC): if low nibble > 9 or HC, add 6. Sub (SBC): if !HC, subtract 6. The nibble arithmetic is mod 16 on the low nibble only.
- DEC_HI, add: if high nibble > 9 or C, add 0x60 and set C=1. Sub: if !C, subtract 0x60 and keep C=0. Arithmetic wraps mod 256.
- COMMIT edge:
  - Write the held result to the destination register.
  - N, Z and V come from the binary alu_Y (NMOS behaviour). C comes from the adjusted carry. Each flag is written only if its mask bit is set.
  - wb_done is 1 in the following cycle.
- Latency from accept edge: binary commits on the 2nd edge; decimal commits on the 4th edge.
- Throughput: one accept per 2 cycles (binary) or 4 cycles (decimal). res_ready falls on the cycle after accept.
- res_valid held while not ready is not lost; it is accepted on the first IDLE cycle.
- Flag-write priority per P bit on the same edge: p_load, then commit, then p_op.
- p_load writes bits 7, 6, 3, 2, 1, 0; bits 5 and 4 always read 1.
- p_op and p_load act in any state with one-edge latency. A D change mid-operation does not affect an already-accepted operation, because the decimal decision is made at accept.
- res_dest = none: flags only; wb_done still pulses.

Optional Feature:
- Macro: DECIMAL_MODE_EN.
- Defined: BCD path as above; CLD/SED modify D.
- Undefined (2A03-style): DEC_LO and DEC_HI are removed; res_decimal is ignored; every operation takes the binary path. D still stores via SED/CLD/p_load but has no arithmetic effect.

Decomposition:
- Shared params include: dest codes, p_op codes, P bit indices (P_N=7 ... P_C=0), FSM state encodings.
- One natural combinational sub-module, bcd_adjust. Inputs: value, carry, half-carry, sub, phase. Outputs: adjusted value and carry. It is instantiated once and used in both DEC_LO and DEC_HI.

Test Plan:
- Binary ADD: alu_Y=0x00, C=1, V=0, dest=A, mask=1111 -> after 2 edges A=0x00, Z=1, C=1, N=0, V=0; wb_done pulses once.
- Decimal ADC: D set, alu_Y=0x0A, HC=0, C=0 -> after 4 edges A=0x10, C=0, Z=0.
- Decimal ADC: alu_Y=0x9A, HC=0, C=0 -> A=0x00, C=1, Z=0 (Z from binary 0x9A), N=1. With DECIMAL_MODE_EN undefined -> A=0x9A after 2 edges, C=0.
- Flags: SEC, then next cycle CLV, then p_load 0x00 -> reg_P=0x30; p_load 0xFF -> reg_P=0xFF. p_op CLC coincident with a commit setting C=1 -> C=1.
- Backpressure: second res_valid asserted while in DEC_HI -> res_ready=0; accepted on the IDLE cycle after COMMIT; both results written in order.
- Reset mid-op: resetn low during DEC_LO -> immediately A=X=Y=0, P=0x34, res_ready=1 after release, no wb_done.
